rvfi_retire_sequencer: RTL
==========================

RVFI_RETIRE_SEQUENCER -- requirements
Module: rvfi_retire_sequencer

Interface
REQ-001 Parameter NRET, default 2, number of parallel retirement input channels.
REQ-002 Parameter PW, default 64, per-channel payload width in bits; the payload carries insn/pc/rd and similar fields, opaque to this block.
REQ-003 Parameter DEPTH, default 8, reorder-buffer slots; power of two, DEPTH >= NRET, DEPTH <= 128.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  NRET  per-channel retirement strobe; no backpressure toward the core.
REQ-007 in_order  input  NRET*8  per-channel retirement order number, channel i at [i*8 +: 8].
REQ-008 in_payload  input  NRET*PW  per-channel payload, channel i at [i*PW +: PW].
REQ-009 out_valid  output  1  head entry available to the single downstream checker channel.
REQ-010 out_ready  input  1  downstream accepts the head entry when high with out_valid.
REQ-011 out_order  output  8  order number of the head entry; always equals the expected counter.
REQ-012 out_payload  output  PW  payload of the head entry.
REQ-013 occupancy  output  $clog2(DEPTH)+1  number of filled slots.
REQ-014 err_range  output  1  sticky flag: an order number fell outside the acceptance window.
REQ-015 err_dup  output  1  sticky flag: a write targeted an already-filled slot or a same-cycle duplicate.

Function
REQ-016 The block SHALL hold an 8-bit expected-order counter, exp, that wraps from 255 to 0.
REQ-017 Each input maps to slot index = in_order mod DEPTH, with delta = (in_order - exp) mod 256; all terms use the exp value from the start of the cycle.
REQ-018 Channel i with delta >= DEPTH SHALL be dropped and SHALL set err_range the next cycle.
REQ-019 Channel i with delta < DEPTH that targets a filled slot SHALL be dropped and SHALL set err_dup; the stored entry SHALL be unchanged.
REQ-020 Same-cycle channels with equal in_order SHALL be resolved by keeping the lowest channel index; the others are dropped and SHALL set err_dup.
REQ-021 An accepted entry SHALL be written to its slot with its valid bit set, and SHALL be visible on the outputs the following cycle (1-cycle latency).
REQ-022 out_valid SHALL equal the valid bit of slot exp mod DEPTH; out_order = exp; out_payload = that slot's payload; these outputs are combinational from registered state.
REQ-023 When out_valid && out_ready, the block SHALL clear the head slot and increment exp by 1 mod 256 in the same edge.
REQ-024 out_payload and out_order SHALL hold stable while out_valid && !out_ready.
REQ-025 A write and a pop can never hit the same slot in one cycle, because a write to the head slot with delta = DEPTH is a range drop; no priority rule is needed for that case.
REQ-026 occupancy SHALL update each cycle by (number accepted) - (1 if popped), and SHALL never exceed DEPTH.
REQ-027 err_range and err_dup SHALL clear only on reset; dropped entries SHALL never reach the output.
REQ-028 When exp wraps 255 -> 0, delta arithmetic SHALL stay mod 256, so order 1 is in-window when exp = 254.

Reset
REQ-029 While resetn is low at a rising edge, all slot valid bits, exp, occupancy, err_range and err_dup SHALL be 0; slot payload contents need not be cleared.
REQ-030 After reset, out_valid = 0, out_order = 0 and occupancy = 0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered entries with no output handshake in that cycle, and SHALL override any simultaneous write or pop.

Verification
REQ-032 NRET=2, ready=1: same cycle ch0 order 1, ch1 order 0 -> next cycle out order 0, then order 1 the cycle after; no errors raised.
REQ-033 ready=0: inputs orders 0..7 one per cycle -> occupancy 8; then order 8 arrives -> dropped, err_range=1, occupancy stays 8.
REQ-034 Order 3 written twice (in different cycles), and separately both channels carry order 5 in one cycle -> err_dup=1; ch0's payload is emitted for 5 and the first payload is emitted for 3.
REQ-035 Preload exp=254, input orders 255, 254, 0, 1 -> output sequence 254, 255, 0, 1; err_range=0.
REQ-036 ready held low with head valid -> out_payload and out_order stable for 5 cycles; ready pulse -> exactly one pop and exp+1.
REQ-037 resetn low for one cycle with occupancy 4 and err_dup=1 -> next cycle occupancy 0, out_valid 0, err flags 0, out_order 0.

Source files
------------

// File: rtl/rvfi_retire_sequencer_if.sv
// Retirement-side and checker-side signal bundle for the RVFI retire sequencer.
// The core/bench drives through master; the sequencer sits on slave.
interface rvfi_retire_sequencer_if #(
   parameter int NRET  = 2,
   parameter int PW    = 64,
   parameter int DEPTH = 8
);
   logic [NRET-1:0]        in_valid;
   logic [NRET*8-1:0]      in_order;
   logic [NRET*PW-1:0]     in_payload;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             out_order;
   logic [PW-1:0]          out_payload;
   logic [$clog2(DEPTH):0] occupancy;
   logic                   err_range;
   logic                   err_dup;

   modport master (
      output in_valid, in_order, in_payload, out_ready,
      input  out_valid, out_order, out_payload, occupancy, err_range, err_dup
   );

   modport slave (
      input  in_valid, in_order, in_payload, out_ready,
      output out_valid, out_order, out_payload, occupancy, err_range, err_dup
   );
endinterface

// File: rtl/rvfi_retire_sequencer.sv
// Reorders out-of-order RVFI retirements into a single in-order stream; 1-cycle write-to-output latency.
// No backpressure toward the core: entries outside the window or hitting a filled slot are dropped and flagged.
module rvfi_retire_sequencer #(
   parameter int NRET  = 2,
   parameter int PW    = 64,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   rvfi_retire_sequencer_if.slave bus
);
   localparam int         IW      = $clog2(DEPTH);
   localparam int         OW      = $clog2(DEPTH) + 1;
   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   logic [DEPTH-1:0] slot_vld;
   logic [PW-1:0]    slot_pay [DEPTH];
   logic [7:0]       exp_ord;
   logic [OW-1:0]    occ;
   logic             err_range_q;
   logic             err_dup_q;

   logic [7:0]       ord      [NRET];
   logic [7:0]       delta    [NRET];
   logic [IW-1:0]    slot_idx [NRET];
   logic [NRET-1:0]  acc;
   logic [NRET-1:0]  drop_range;
   logic [NRET-1:0]  drop_dup;
   logic [NRET-1:0]  same_dup;
   logic [IW-1:0]    head;
   logic             pop;
   logic [OW-1:0]    occ_nxt;

   // All window and slot checks use the start-of-cycle counter and slot state.
   always_comb begin
      head       = exp_ord[IW-1:0];
      pop        = slot_vld[head] & bus.out_ready;
      acc        = '0;
      drop_range = '0;
      drop_dup   = '0;
      same_dup   = '0;
      occ_nxt    = occ - OW'(pop);
      for (int i = 0; i < NRET; i++) begin
         ord[i]      = bus.in_order[i*8 +: 8];
         delta[i]    = ord[i] - exp_ord;
         slot_idx[i] = ord[i][IW-1:0];
      end
      for (int i = 0; i < NRET; i++) begin
         for (int j = 0; j < NRET; j++) begin
            if (j < i && bus.in_valid[j] && ord[j] == ord[i]) begin
               same_dup[i] = 1'b1;
            end
         end
         if (bus.in_valid[i]) begin
            if ({1'b0, delta[i]} >= DEPTH_W) begin
               drop_range[i] = 1'b1;
            end else if (slot_vld[slot_idx[i]] || same_dup[i]) begin
               drop_dup[i] = 1'b1;
            end else begin
               acc[i]  = 1'b1;
               occ_nxt = occ_nxt + OW'(1);
            end
         end
      end
   end

   // A head write needs delta == 0 on an empty head, so it never collides with a pop.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         slot_vld    <= '0;
         exp_ord     <= '0;
         occ         <= '0;
         err_range_q <= 1'b0;
         err_dup_q   <= 1'b0;
      end else begin
         if (pop) begin
            slot_vld[head] <= 1'b0;
            exp_ord        <= exp_ord + 8'd1;
         end
         for (int i = 0; i < NRET; i++) begin
            if (acc[i]) begin
               slot_vld[slot_idx[i]] <= 1'b1;
            end
         end
         occ <= occ_nxt;
         if (|drop_range) begin
            err_range_q <= 1'b1;
         end
         if (|drop_dup) begin
            err_dup_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NRET; i++) begin
         if (acc[i] && resetn) begin
            slot_pay[slot_idx[i]] <= bus.in_payload[i*PW +: PW];
         end
      end
   end

   assign bus.out_valid   = slot_vld[head];
   assign bus.out_order   = exp_ord;
   assign bus.out_payload = slot_pay[head];
   assign bus.occupancy   = occ;
   assign bus.err_range   = err_range_q;
   assign bus.err_dup     = err_dup_q;
endmodule
